// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract controller.
//   DEFAULT_WIDTH : default operand/result width.
//   ST_IDLE/ST_RUN/ST_DONE : controller state encodings.
//   cnt_width()   : width of the bit counter for a given operand width.
package serial_add_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(w)); w is at least 2, so the result is at least 1.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sub_ctrl_fa.sv
// One-bit full adder used as the single arithmetic element of the
// serial add/subtract datapath.
//   A, B : operand bits
//   cin  : carry in
//   sum  : sum bit
//   co   : carry out
module FA (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic sum,
  output logic co
);

  assign sum = A ^ B ^ cin;
  assign co  = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtractor. One operation computes A+B (op=0) or A-B
// (op=1), LSB first, one bit per clock through a single full adder.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin an operation (only honoured in IDLE)
//   op       : 0 = add, 1 = subtract (sampled with start)
//   A, B     : operands (sampled with start)
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when result/cout/overflow are valid
//   result   : sum/difference, modulo 2^WIDTH
//   cout     : carry out of the MSB (for subtract, 1 = no borrow)
//   overflow : signed two's-complement overflow
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_co;

  FA u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = A;
          b_d     = B ^ {WIDTH{op}};
          carry_d = op;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB; fa_co the carry out of it.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;

  localparam int W = 32;
  localparam int EXP_LAT = W + 1;  // cycles from the start cycle to the done cycle

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int passed = 0;
  int total  = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide arithmetic with signed-overflow rules.
  function automatic void ref_model(input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] full;
    if (!o) full = {1'b0, a} + {1'b0, b};
    else    full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    r = full[W-1:0];
    c = full[W];
    if (!o) v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    else    v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  // Runs one operation starting at the current negedge; returns at the
  // negedge of the cycle after done (the cycle done drops).
  task automatic run_op(input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_cycle,
                        output logic [W-1:0] r, output logic c, output logic v,
                        output int lat, output bit pulse_ok, output bit flags_ok,
                        output bit hold_ok);
    lat = -1; pulse_ok = 1'b0; flags_ok = 1'b1; hold_ok = 1'b0;
    r = 'x; c = 1'bx; v = 1'bx;
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); A = $urandom; B = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (busy && done) flags_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) flags_ok = 1'b0;
      if (k == poke_cycle) begin
        start = 1'b1; op = ~o; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (lat > 0) begin
      r = result; c = cout; v = overflow;
      @(negedge clk);
      pulse_ok = (done === 1'b0);
      hold_ok  = (result === r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 1'b0; A = 32'd5; B = 32'd3;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else passed++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_directed();
    bit           t_op [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] t_a  [5]  = '{32'd5, 32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] t_b  [5]  = '{32'd3, 32'd5, 32'd1, 32'd1, 32'd1};
    logic [W-1:0] t_r  [5]  = '{32'd8, 32'hFFFFFFFE, 32'h80000000, 32'h0, 32'h7FFFFFFF};
    bit           t_c  [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit           t_v  [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] r; logic c, v; int lat; bit p, f, h;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 0, r, c, v, lat, p, f, h);
      total++; if (lat != EXP_LAT) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, EXP_LAT); else passed++;
      total++; if (r !== t_r[i]) $display("FAIL dir%0d_result: got %h want %h", i, r, t_r[i]); else passed++;
      total++; if (c !== t_c[i]) $display("FAIL dir%0d_cout: got %b want %b", i, c, t_c[i]); else passed++;
      total++; if (v !== t_v[i]) $display("FAIL dir%0d_overflow: got %b want %b", i, v, t_v[i]); else passed++;
      total++; if (!p) $display("FAIL dir%0d_pulse: got done still high want single pulse", i); else passed++;
      total++; if (!f) $display("FAIL dir%0d_busy_flags: got bad busy/done want busy only in run", i); else passed++;
      $display("directed op=%0d A=%h B=%h -> result=%h cout=%b ovf=%b lat=%0d", t_op[i], t_a[i], t_b[i], r, c, v, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er; logic c, v, ec, ev; int lat; bit o, p, f, h;
    for (int i = 0; i < 30; i++) begin
      o = 1'($urandom);
      a = $urandom; b = $urandom;
      if (i % 5 == 1) a = {1'b0, {(W-1){1'b1}}};
      if (i % 5 == 2) b = {1'b1, {(W-1){1'b0}}};
      ref_model(o, a, b, er, ec, ev);
      run_op(o, a, b, 0, r, c, v, lat, p, f, h);
      total++; if (lat != EXP_LAT) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, EXP_LAT); else passed++;
      total++; if (r !== er) $display("FAIL rnd%0d_result: got %h want %h", i, r, er); else passed++;
      total++; if (c !== ec) $display("FAIL rnd%0d_cout: got %b want %b", i, c, ec); else passed++;
      total++; if (v !== ev) $display("FAIL rnd%0d_overflow: got %b want %b", i, v, ev); else passed++;
      $display("random op=%0d A=%h B=%h -> result=%h cout=%b ovf=%b", o, a, b, r, c, v);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] r, er; logic c, v, ec, ev; int lat; bit p, f, h;
    ref_model(1'b0, 32'h12345678, 32'h0F0F0F0F, er, ec, ev);
    run_op(1'b0, 32'h12345678, 32'h0F0F0F0F, 10, r, c, v, lat, p, f, h);
    total++; if (lat != EXP_LAT) $display("FAIL ignore_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    total++; if (r !== er) $display("FAIL ignore_result: got %h want %h", r, er); else passed++;
    total++; if (c !== ec) $display("FAIL ignore_cout: got %b want %b", c, ec); else passed++;
    total++; if (!h) $display("FAIL ignore_hold: got result changed after done want held"); else passed++;
    $display("ignore_start: result=%h with start poked at cycle 10", r);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er; logic c, v, ec, ev; int lat; bit p, f, h;
    // Entered at the negedge of the cycle done dropped, so this start lands there.
    ref_model(1'b1, 32'h00000010, 32'h00000020, er, ec, ev);
    run_op(1'b1, 32'h00000010, 32'h00000020, 0, r, c, v, lat, p, f, h);
    total++; if (lat != EXP_LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    total++; if (r !== er) $display("FAIL b2b_result: got %h want %h", r, er); else passed++;
    total++; if (c !== ec) $display("FAIL b2b_cout: got %b want %b", c, ec); else passed++;
    total++; if (v !== ev) $display("FAIL b2b_overflow: got %b want %b", v, ev); else passed++;
    $display("back_to_back: result=%h cout=%b ovf=%b", r, c, v);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] r; logic c, v; int lat; bit p, f, h, saw_done;
    start = 1'b1; op = 1'b0; A = 32'hFFFF0000; B = 32'h0000FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (result !== '0) $display("FAIL abort_result: got %h want 0", result); else passed++;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_done) $display("FAIL abort_no_done: got done pulse want none"); else passed++;
    run_op(1'b0, 32'd5, 32'd3, 0, r, c, v, lat, p, f, h);
    total++; if (r !== 32'd8) $display("FAIL abort_then_add: got %h want %h", r, 32'd8); else passed++;
    total++; if (lat != EXP_LAT) $display("FAIL abort_then_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
    $display("reset_abort: after abort 5+3=%h", r);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
